// File: rtl/fpu_issue_ctrl.sv
// Issue controller and writeback scheduler for the fadd/fmul/ftoi/itof FPU units.
// A latency reservation ring keeps unit results from ever colliding on the shared writeback port.
module fpu_issue_ctrl #(
  parameter int unsigned LAT_FADD = 3,
  parameter int unsigned LAT_FMUL = 2,
  parameter int unsigned LAT_FTOI = 1,
  parameter int unsigned LAT_ITOF = 2,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       issue_op,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  output logic [31:0]      unit_a,
  output logic [31:0]      unit_b,
  output logic             fadd_stage1_valid,
  output logic             fmul_stage1_valid,
  output logic             ftoi_stage1_valid,
  output logic             itof_stage1_valid,
  input  logic [31:0]      fadd_y,
  input  logic             fadd_valid,
  input  logic [31:0]      fmul_y,
  input  logic             fmul_valid,
  input  logic [31:0]      ftoi_y,
  input  logic             ftoi_valid,
  input  logic [31:0]      itof_y,
  input  logic             itof_valid,
  input  logic             flush,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic [3:0]       inflight,
  output logic             lat_err
);

  typedef enum logic [1:0] {
    OP_FADD = 2'd0,
    OP_FMUL = 2'd1,
    OP_FTOI = 2'd2,
    OP_ITOF = 2'd3
  } op_e;

  typedef struct packed {
    logic             v;
    op_e              unit;
    logic [TAG_W-1:0] tag;
  } slot_t;

  localparam logic [2:0] LAT_FADD_C = 3'(LAT_FADD);
  localparam logic [2:0] LAT_FMUL_C = 3'(LAT_FMUL);
  localparam logic [2:0] LAT_FTOI_C = 3'(LAT_FTOI);
  localparam logic [2:0] LAT_ITOF_C = 3'(LAT_ITOF);

  // Slot k holds the operation whose unit result is valid k cycles from now.
  slot_t       slot_q [8];
  slot_t       slot_d [8];
  logic [2:0]  lat_sel;
  logic [2:0]  ins_idx;
  logic        fire;
  logic [31:0] res_y;
  logic        res_v;

  assign unit_a = issue_a;
  assign unit_b = issue_b;

  // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lat_sel = LAT_FADD_C;
    unique case (issue_op)
      2'd0: lat_sel = LAT_FADD_C;
      2'd1: lat_sel = LAT_FMUL_C;
      2'd2: lat_sel = LAT_FTOI_C;
      2'd3: lat_sel = LAT_ITOF_C;
    endcase
    ins_idx = lat_sel - 3'd1;

    // Slot L before the shift becomes slot L-1 after it, which is where this op would land.
    issue_ready = !rst && !flush && !slot_q[lat_sel].v;
    fire        = issue_valid && issue_ready;

    fadd_stage1_valid = fire && (issue_op == OP_FADD);
    fmul_stage1_valid = fire && (issue_op == OP_FMUL);
    ftoi_stage1_valid = fire && (issue_op == OP_FTOI);
    itof_stage1_valid = fire && (issue_op == OP_ITOF);
  end

  always_comb begin
    res_y = fadd_y;
    res_v = fadd_valid;
    unique case (slot_q[0].unit)
      OP_FADD: begin res_y = fadd_y; res_v = fadd_valid; end
      OP_FMUL: begin res_y = fmul_y; res_v = fmul_valid; end
      OP_FTOI: begin res_y = ftoi_y; res_v = ftoi_valid; end
      OP_ITOF: begin res_y = itof_y; res_v = itof_valid; end
    endcase
  end

  always_comb begin
    for (int k = 0; k < 7; k++) slot_d[k] = slot_q[k+1];
    slot_d[7] = '0;
    if (fire) slot_d[ins_idx] = '{v: 1'b1, unit: op_e'(issue_op), tag: issue_tag};
    if (flush) begin
      for (int k = 0; k < 8; k++) slot_d[k].v = 1'b0;
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < 8; k++) inflight = inflight + 4'(slot_q[k].v);
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) slot_q[k] <= '0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
      lat_err  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      wb_valid <= slot_q[0].v && !flush;
      if (slot_q[0].v && !flush) begin
        wb_tag  <= slot_q[0].tag;
        wb_data <= res_y;
      end
      // Results emerging without a reservation (after flush or reset) never reach this check.
      if (slot_q[0].v && !res_v) lat_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: emulates the four units and compares the DUT
// every cycle against a reservation-calendar model, plus directed literal checks.
module tb_fpu_issue_ctrl;

  localparam int TAG_W = 5;

  logic             clk;
  logic             rst;
  logic             issue_valid;
  logic             issue_ready;
  logic [1:0]       issue_op;
  logic [TAG_W-1:0] issue_tag;
  logic [31:0]      issue_a;
  logic [31:0]      issue_b;
  logic [31:0]      unit_a;
  logic [31:0]      unit_b;
  logic             fadd_stage1_valid;
  logic             fmul_stage1_valid;
  logic             ftoi_stage1_valid;
  logic             itof_stage1_valid;
  logic             flush;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;
  logic [3:0]       inflight;
  logic             lat_err;

  logic [3:0]       drv_v;
  logic [31:0]      drv_y [4];

  fpu_issue_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_op          (issue_op),
    .issue_tag         (issue_tag),
    .issue_a           (issue_a),
    .issue_b           (issue_b),
    .unit_a            (unit_a),
    .unit_b            (unit_b),
    .fadd_stage1_valid (fadd_stage1_valid),
    .fmul_stage1_valid (fmul_stage1_valid),
    .ftoi_stage1_valid (ftoi_stage1_valid),
    .itof_stage1_valid (itof_stage1_valid),
    .fadd_y            (drv_y[0]),
    .fadd_valid        (drv_v[0]),
    .fmul_y            (drv_y[1]),
    .fmul_valid        (drv_v[1]),
    .ftoi_y            (drv_y[2]),
    .ftoi_valid        (drv_v[2]),
    .itof_y            (drv_y[3]),
    .itof_valid        (drv_v[3]),
    .flush             (flush),
    .wb_valid          (wb_valid),
    .wb_tag            (wb_tag),
    .wb_data           (wb_data),
    .inflight          (inflight),
    .lat_err           (lat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Unit emulation: result calendar indexed by cycle modulo 64.
  logic        sched_v [4][64];
  logic [31:0] sched_y [4][64];
  logic        drop_fmul = 1'b0;

  // Model: reservations keyed by the cycle the result arrives.
  logic             res_v   [64];
  logic [1:0]       res_u   [64];
  logic [TAG_W-1:0] res_tag [64];
  logic             m_wb_v    = 1'b0;
  logic [TAG_W-1:0] m_wb_tag  = '0;
  logic [31:0]      m_wb_data = '0;
  logic             m_lat_err = 1'b0;

  int wb_tag_at [int];
  int max_if = 0;
  logic [3:0] last_strobe = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'd0: return 3;
      2'd1: return 2;
      2'd2: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] unit_fn(input logic [1:0] u, input logic [31:0] a, input logic [31:0] b);
    case (u)
      2'd0: return a + b;
      2'd1: return a * b;
      2'd2: return (a == 32'h412828f6) ? 32'h0000000a : a >> 4;
      default: return {a[15:0], b[15:0]};
    endcase
  endfunction

  task automatic sched_unit(input logic [1:0] u, input int at);
    if (u == 2'd1 && drop_fmul) drop_fmul = 1'b0;
    else begin
      sched_v[u][at % 64] = 1'b1;
      sched_y[u][at % 64] = unit_fn(u, issue_a, issue_b);
    end
  endtask

  // Monitor: drives unit results after each edge, then checks and advances the model at the falling edge.
  initial begin
    for (int i = 0; i < 64; i++) begin
      res_v[i] = 1'b0;
      res_u[i] = '0;
      res_tag[i] = '0;
      for (int u = 0; u < 4; u++) begin
        sched_v[u][i] = 1'b0;
        sched_y[u][i] = '0;
      end
    end
    drv_v = '0;
    for (int u = 0; u < 4; u++) drv_y[u] = '0;
    forever begin
      int idx;
      int l;
      int cnt;
      logic exp_ready;
      logic exp_fire;
      @(posedge clk);
      cyc++;
      #1;
      idx = cyc % 64;
      for (int u = 0; u < 4; u++) begin
        drv_v[u] = sched_v[u][idx];
        drv_y[u] = sched_v[u][idx] ? sched_y[u][idx] : (32'h0bad0000 ^ 32'(cyc));
      end
      @(negedge clk);
      l = lat_of(issue_op);
      exp_ready = !rst && !flush && !res_v[(cyc + l) % 64];
      exp_fire  = issue_valid && exp_ready;
      cnt = 0;
      for (int i = 0; i < 64; i++) cnt += int'(res_v[i]);

      check("issue_ready", 64'(issue_ready), 64'(exp_ready));
      check("fadd_strobe", 64'(fadd_stage1_valid), 64'(exp_fire && issue_op == 2'd0));
      check("fmul_strobe", 64'(fmul_stage1_valid), 64'(exp_fire && issue_op == 2'd1));
      check("ftoi_strobe", 64'(ftoi_stage1_valid), 64'(exp_fire && issue_op == 2'd2));
      check("itof_strobe", 64'(itof_stage1_valid), 64'(exp_fire && issue_op == 2'd3));
      check("unit_a", 64'(unit_a), 64'(issue_a));
      check("unit_b", 64'(unit_b), 64'(issue_b));
      check("wb_valid", 64'(wb_valid), 64'(m_wb_v));
      if (m_wb_v) check("wb_tag", 64'(wb_tag), 64'(m_wb_tag));
      check("wb_data", 64'(wb_data), 64'(m_wb_data));
      check("inflight", 64'(inflight), 64'(cnt));
      check("lat_err", 64'(lat_err), 64'(m_lat_err));

      wb_tag_at[cyc] = wb_valid ? int'(wb_tag) : -1;
      if (int'(inflight) > max_if) max_if = int'(inflight);

      // Units respond to whatever strobes the DUT actually raised.
      if (fadd_stage1_valid) sched_unit(2'd0, cyc + lat_of(2'd0));
      if (fmul_stage1_valid) sched_unit(2'd1, cyc + lat_of(2'd1));
      if (ftoi_stage1_valid) sched_unit(2'd2, cyc + lat_of(2'd2));
      if (itof_stage1_valid) sched_unit(2'd3, cyc + lat_of(2'd3));

      if (rst) begin
        for (int i = 0; i < 64; i++) res_v[i] = 1'b0;
        m_wb_v    = 1'b0;
        m_wb_tag  = '0;
        m_wb_data = '0;
        m_lat_err = 1'b0;
      end else begin
        if (res_v[idx] && !drv_v[res_u[idx]]) m_lat_err = 1'b1;
        m_wb_v = res_v[idx] && !flush;
        if (m_wb_v) begin
          m_wb_tag  = res_tag[idx];
          m_wb_data = drv_y[res_u[idx]];
        end
        if (flush) begin
          for (int i = 0; i < 64; i++) res_v[i] = 1'b0;
        end else res_v[idx] = 1'b0;
        if (exp_fire) begin
          res_v[(cyc + l) % 64]   = 1'b1;
          res_u[(cyc + l) % 64]   = issue_op;
          res_tag[(cyc + l) % 64] = issue_tag;
        end
      end
      for (int u = 0; u < 4; u++) sched_v[u][idx] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Leaves the caller at the falling edge of cycle t; the caller finishes with tick().
  task automatic at_cycle(input int t);
    int guard = 0;
    while (cyc < t && guard < 200) begin
      tick();
      guard++;
    end
    if (cyc != t) check("at_cycle", 64'(cyc), 64'(t));
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                       input logic [31:0] a, input logic [31:0] b, output int fc);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_tag   = tag;
    issue_a     = a;
    issue_b     = b;
    fc = -1;
    for (int n = 0; n < 12 && fc < 0; n++) begin
      @(negedge clk);
      if (issue_ready) begin
        fc = cyc;
        last_strobe = {itof_stage1_valid, ftoi_stage1_valid, fmul_stage1_valid, fadd_stage1_valid};
      end
      tick();
    end
    issue_valid = 1'b0;
    if (fc < 0) check("issue_timeout", 64'(fc), 64'(0));
  endtask

  task automatic check_wb(input int t, input logic [TAG_W-1:0] tag, input logic [31:0] data, input string name);
    at_cycle(t);
    check({name, "_valid"}, 64'(wb_valid), 64'(1));
    check({name, "_tag"}, 64'(wb_tag), 64'(tag));
    check({name, "_data"}, 64'(wb_data), 64'(data));
    tick();
  endtask

  initial begin
    int fc;
    int fa;
    int fb;
    int fcc;
    int first;
    int found;
    rst = 1'b1;
    flush = 1'b0;
    issue_valid = 1'b0;
    issue_op = '0;
    issue_tag = '0;
    issue_a = '0;
    issue_b = '0;
    tick();
    idle(3);
    at_cycle(cyc);
    check("reset_inflight", 64'(inflight), 64'(0));
    check("reset_wb_valid", 64'(wb_valid), 64'(0));
    check("reset_ready", 64'(issue_ready), 64'(0));
    tick();
    rst = 1'b0;
    idle(2);

    // ftoi latency 1: strobe at T, writeback at T+2.
    issue(2'd2, 5'd3, 32'h412828f6, 32'h0, fc);
    check("ftoi_strobe_vec", 64'(last_strobe), 64'(4'b0100));
    check_wb(fc + 2, 5'd3, 32'h0000000a, "ftoi_wb");
    idle(4);

    // fadd at T and fmul at T+1 both target T+3; fmul must slip a cycle.
    issue(2'd0, 5'd1, 32'd1, 32'd2, fa);
    issue_valid = 1'b1;
    issue_op = 2'd1;
    issue_tag = 5'd2;
    issue_a = 32'd3;
    issue_b = 32'd4;
    @(negedge clk);
    check("conflict_ready", 64'(issue_ready), 64'(0));
    tick();
    issue(2'd1, 5'd2, 32'd3, 32'd4, fb);
    check("fmul_fire_cycle", 64'(fb), 64'(fa + 2));
    check_wb(fa + 4, 5'd1, 32'd3, "fadd_wb");
    check_wb(fa + 5, 5'd2, 32'd12, "fmul_wb");
    idle(4);

    // Eight back-to-back ftoi ops.
    max_if = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      issue(2'd2, 5'(i), 32'h100 * 32'(i + 1), 32'h0, fc);
      if (i == 0) first = fc;
      check("burst_fire_cycle", 64'(fc), 64'(first + i));
    end
    idle(4);
    for (int i = 0; i < 8; i++) check("burst_wb_tag", 64'(wb_tag_at[first + 2 + i]), 64'(i));
    check("burst_inflight_max", 64'(max_if), 64'(1));
    idle(2);

    // Flush with fmul and itof still in flight.
    issue(2'd0, 5'd4, 32'd10, 32'd20, fa);
    issue(2'd1, 5'd5, 32'd6, 32'd7, fb);
    issue(2'd3, 5'd6, 32'h1234, 32'h5678, fcc);
    check("flush_fmul_fire", 64'(fb), 64'(fa + 2));
    check("flush_itof_fire", 64'(fcc), 64'(fa + 3));
    flush = 1'b1;
    @(negedge clk);
    check("flush_ready", 64'(issue_ready), 64'(0));
    tick();
    flush = 1'b0;
    at_cycle(cyc);
    check("flush_inflight", 64'(inflight), 64'(0));
    check("flush_wb_valid", 64'(wb_valid), 64'(0));
    tick();
    idle(6);
    found = 0;
    for (int c = fcc; c < fcc + 9; c++) begin
      if (wb_tag_at[c] == 5 || wb_tag_at[c] == 6) found++;
    end
    check("flushed_wb_count", 64'(found), 64'(0));
    check("flush_fadd_wb", 64'(wb_tag_at[fa + 4]), 64'(4));
    at_cycle(cyc);
    check("flush_lat_err", 64'(lat_err), 64'(0));
    tick();
    idle(2);

    // fmul result withheld: lat_err rises at T+3 and sticks.
    drop_fmul = 1'b1;
    issue(2'd1, 5'd9, 32'd5, 32'd6, fc);
    at_cycle(fc + 2);
    check("lat_err_before", 64'(lat_err), 64'(0));
    tick();
    at_cycle(fc + 3);
    check("lat_err_set", 64'(lat_err), 64'(1));
    tick();
    idle(6);
    at_cycle(cyc);
    check("lat_err_sticky", 64'(lat_err), 64'(1));
    tick();

    // Reset with three fadds in flight.
    issue(2'd0, 5'd10, 32'd100, 32'd1, fa);
    issue(2'd0, 5'd11, 32'd200, 32'd2, fb);
    issue(2'd0, 5'd12, 32'd300, 32'd3, fcc);
    at_cycle(cyc);
    check("pre_reset_inflight", 64'(inflight), 64'(3));
    tick();
    rst = 1'b1;
    tick();
    at_cycle(cyc);
    check("rst_inflight", 64'(inflight), 64'(0));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_ready", 64'(issue_ready), 64'(0));
    check("rst_lat_err", 64'(lat_err), 64'(0));
    tick();
    rst = 1'b0;
    idle(6);
    issue(2'd2, 5'd13, 32'h412828f6, 32'h0, fc);
    check_wb(fc + 2, 5'd13, 32'h0000000a, "post_rst_wb");
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
